// File: rtl/regfile_scoreboard.sv
// 32-entry register file with same-cycle writeback bypass and a per-register
// pending-write scoreboard that stalls issue on RAW hazards or a saturated counter.
module regfile_scoreboard #(
  parameter int DATA_SIZE = 32,
  parameter int PEND_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [4:0]           WB_dest,
  input  logic [DATA_SIZE-1:0] WB_value,
  input  logic                 WB_WEenable,
  input  logic [4:0]           rs_addr,
  input  logic [4:0]           rt_addr,
  output logic [DATA_SIZE-1:0] rs_data,
  output logic [DATA_SIZE-1:0] rt_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_dest,
  output logic                 stall,
  output logic                 pend_err
);

  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1'b1);

  // Entry 0 of both arrays is never loaded, so it stays at its reset value of 0.
  logic [DATA_SIZE-1:0] mem_q [32];
  logic [DATA_SIZE-1:0] mem_d [32];
  logic [PEND_W-1:0]    cnt_q [32];
  logic [PEND_W-1:0]    cnt_d [32];
  logic [PEND_W-1:0]    eff_s [32];
  logic [31:0]          wb_hit_s;
  logic [31:0]          busy_s;
  logic [31:0]          inc_s;
  logic [31:0]          dec_s;
  logic                 issue_acc_s;
  logic                 pend_err_q;
  logic                 pend_err_d;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      wb_hit_s[r] = WB_WEenable && (WB_dest != 5'd0) && (WB_dest == 5'(r));
      if (wb_hit_s[r] && (cnt_q[r] != CNT_ZERO)) begin
        eff_s[r] = cnt_q[r] - CNT_ONE;
      end else begin
        eff_s[r] = cnt_q[r];
      end
      busy_s[r] = (eff_s[r] != CNT_ZERO);
    end
  end

  always_comb begin
    stall = issue_valid && (busy_s[rs_addr] || busy_s[rt_addr] ||
            ((issue_dest != 5'd0) && (eff_s[issue_dest] == CNT_MAX)));
    issue_acc_s = issue_valid && !stall;
  end

  // Read ports: r0 is hard zero, a writeback in flight wins over the array.
  always_comb begin
    if (rs_addr == 5'd0) begin
      rs_data = {DATA_SIZE{1'b0}};
    end else if (WB_WEenable && (WB_dest == rs_addr)) begin
      rs_data = WB_value;
    end else begin
      rs_data = mem_q[rs_addr];
    end
    if (rt_addr == 5'd0) begin
      rt_data = {DATA_SIZE{1'b0}};
    end else if (WB_WEenable && (WB_dest == rt_addr)) begin
      rt_data = WB_value;
    end else begin
      rt_data = mem_q[rt_addr];
    end
  end

  // Next-state for array and counters; counters saturate and flag instead of wrapping.
  always_comb begin
    pend_err_d = pend_err_q;
    for (int r = 0; r < 32; r++) begin
      inc_s[r] = issue_acc_s && (issue_dest != 5'd0) && (issue_dest == 5'(r));
      dec_s[r] = wb_hit_s[r] && (cnt_q[r] != CNT_ZERO);
      if (wb_hit_s[r]) begin
        mem_d[r] = WB_value;
      end else begin
        mem_d[r] = mem_q[r];
      end
      if (wb_hit_s[r] && (cnt_q[r] == CNT_ZERO)) begin
        pend_err_d = 1'b1;
      end else begin
        pend_err_d = pend_err_d;
      end
      case ({inc_s[r], dec_s[r]})
        2'b10: begin
          if (cnt_q[r] == CNT_MAX) begin
            cnt_d[r]   = cnt_q[r];
            pend_err_d = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
          end
        end
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        mem_q[r] <= {DATA_SIZE{1'b0}};
        cnt_q[r] <= CNT_ZERO;
      end
      pend_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
      end
      pend_err_q <= pend_err_d;
    end
  end

  assign pend_err = pend_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: bypass, r0, RAW stall,
// saturation, simultaneous issue/writeback and mid-run reset.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset_n;
  logic [4:0]  WB_dest;
  logic [31:0] WB_value;
  logic        WB_WEenable;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        stall;
  logic        pend_err;

  int n_checks;
  int n_fails;

  regfile_scoreboard #(.DATA_SIZE(32), .PEND_W(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .WB_dest     (WB_dest),
    .WB_value    (WB_value),
    .WB_WEenable (WB_WEenable),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .stall       (stall),
    .pend_err    (pend_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [4:0] idst, input logic we,
                       input logic [4:0] wdst, input logic [31:0] wval);
    issue_valid = iv;
    issue_dest  = idst;
    WB_WEenable = we;
    WB_dest     = wdst;
    WB_value    = wval;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n = 1'b0;
    rs_addr = 5'd5;
    rt_addr = 5'd0;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    // Reset state; the issue held during reset must be discarded.
    check_eq("rst_pend_err", 32'(pend_err), 32'h0);
    check_eq("rst_rs_data", rs_data, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'h0);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("rst_cnt5", 32'(dut.cnt_q[5]), 32'h0);

    // Bypass: pend reg 5, then write it back and read in the same cycle.
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
    tick();
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check_eq("byp_rs_same", rs_data, 32'hDEADBEEF);
    check_eq("byp_rt_other", rt_data, 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("byp_rs_next", rs_data, 32'hDEADBEEF);
    check_eq("byp_pend_err", 32'(pend_err), 32'h0);

    // r0 is never written and always reads zero.
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    drive(1'b0, 5'd0, 1'b1, 5'd0, 32'h12345678);
    check_eq("r0_rs_same", rs_data, 32'h0);
    check_eq("r0_rt_same", rt_data, 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("r0_rs_after", rs_data, 32'h0);
    check_eq("r0_mem", dut.mem_q[0], 32'h0);
    check_eq("r0_cnt", 32'(dut.cnt_q[0]), 32'h0);
    check_eq("r0_pend_err", 32'(pend_err), 32'h0);

    // RAW stall cleared by a same-cycle writeback.
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    check_eq("raw_first_stall", 32'(stall), 32'h0);
    tick();
    rs_addr = 5'd7;
    rt_addr = 5'd7;
    drive(1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
    check_eq("raw_stall", 32'(stall), 32'h1);
    drive(1'b1, 5'd8, 1'b1, 5'd7, 32'h00000077);
    check_eq("raw_stall_clr", 32'(stall), 32'h0);
    check_eq("raw_rs_byp", rs_data, 32'h00000077);
    check_eq("raw_rt_byp", rt_data, 32'h00000077);
    tick();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    drive(1'b0, 5'd0, 1'b1, 5'd8, 32'h00000088);
    check_eq("raw_cnt7", 32'(dut.cnt_q[7]), 32'h0);
    check_eq("raw_cnt8", 32'(dut.cnt_q[8]), 32'h1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("raw_cnt8_done", 32'(dut.cnt_q[8]), 32'h0);
    check_eq("raw_pend_err", 32'(pend_err), 32'h0);

    // Saturation at 3 pending writes to reg 9, then underflow on a fourth writeback.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
      check_eq("sat_issue_stall", 32'(stall), 32'h0);
      tick();
    end
    check_eq("sat_cnt3", 32'(dut.cnt_q[9]), 32'h3);
    drive(1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
    check_eq("sat_stall", 32'(stall), 32'h1);
    tick();
    check_eq("sat_cnt_hold", 32'(dut.cnt_q[9]), 32'h3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h90 + 32'(i));
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("sat_cnt0", 32'(dut.cnt_q[9]), 32'h0);
    check_eq("sat_no_err", 32'(pend_err), 32'h0);
    drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    rs_addr = 5'd9;
    #1;
    check_eq("under_err", 32'(pend_err), 32'h1);
    check_eq("under_cnt", 32'(dut.cnt_q[9]), 32'h0);
    check_eq("under_write", rs_data, 32'h99);
    rs_addr = 5'd0;

    // Simultaneous issue and writeback to reg 4 leave the counter unchanged.
    drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd4, 32'h44);
    check_eq("sim_stall", 32'(stall), 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    rs_addr = 5'd4;
    #1;
    check_eq("sim_cnt4", 32'(dut.cnt_q[4]), 32'h1);
    check_eq("sim_reg4", rs_data, 32'h44);
    rs_addr = 5'd0;

    // Mid-run reset wipes pending state, data and the sticky error.
    drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 32'hA5);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    rs_addr = 5'd3;
    #1;
    check_eq("mid_cnt3_pre", 32'(dut.cnt_q[3]), 32'h2);
    check_eq("mid_reg3_pre", rs_data, 32'hA5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("mid_stall", 32'(stall), 32'h0);
    check_eq("mid_reg3", rs_data, 32'h0);
    check_eq("mid_pend_err", 32'(pend_err), 32'h0);
    check_eq("mid_cnt3", 32'(dut.cnt_q[3]), 32'h0);
    drive(1'b0, 5'd0, 1'b1, 5'd3, 32'h33);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check_eq("mid_late_wb_err", 32'(pend_err), 32'h1);
    check_eq("mid_late_wb_data", rs_data, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
